ethernet_tx_scheduler: RTL and testbench
========================================

// Module: ethernet_tx_scheduler
// PURPOSE
//  Shares the single ethernet_sender TX buffer among num_req_p requesters (cores/DMA).
//  Arbitrates round-robin on packet descriptors. Streams the granted requester's words into
//  the sender buffer through packet_wsize/packet_w*, then pulses packet_send.
//  Sits between requesters and ethernet_sender on clk_i, in place of CSR-driven TX writes.
// PARAMETERS
//  data_width_p  32    requester/sender word width, bits; power of 2, >=16
//  eth_mtu_p     2048  max packet length, bytes
//  num_req_p     2     number of requesters, 1..4
//  (derived) bpw=data_width_p/8; size_w=$clog2(eth_mtu_p+1); addr_w=$clog2(eth_mtu_p); id_w=max(1,$clog2(num_req_p))
// PORTS
//  clk_i                  in   1                    clock
//  reset_i                in   1                    reset, synchronous, active-high
//  req_v_i                in   num_req_p            descriptor valid, one bit per requester
//  req_size_i             in   num_req_p*size_w     packet length in bytes, per requester
//  req_yumi_o             out  num_req_p            descriptor consumed (1-cycle pulse)
//  data_v_i               in   num_req_p            payload word valid
//  data_i                 in   num_req_p*data_width_p  payload words, little-endian bytes
//  data_ready_o           out  num_req_p            payload word accepted when v&ready
//  done_o                 out  num_req_p            packet handed to sender (1-cycle pulse)
//  err_o                  out  num_req_p            descriptor rejected, bad size (1-cycle pulse)
//  busy_o                 out  1                    state != IDLE
//  grant_id_o             out  id_w                 current/last granted requester
//  packet_req_i           in   1                    sender buffer free for a new packet
//  packet_wsize_valid_o   out  1                    write packet length to sender
//  packet_wsize_o         out  size_w               packet length, bytes
//  packet_wvalid_o        out  1                    write one word into sender buffer
//  packet_waddr_o         out  addr_w               byte address of word
//  packet_wdata_o         out  data_width_p         word data
//  packet_wdata_size_o    out  $clog2(size_w)...    always $clog2(bpw) (full word)
//  packet_send_o          out  1                    start transmission (1-cycle pulse)
// BEHAVIOUR
//  Reset: state=IDLE; rr pointer last_r=num_req_p-1 (req 0 wins first); size_r/addr_r/grant=0.
//   All outputs 0 except packet_wdata_size_o constant. Reset mid-packet: abort, no send pulse.
//  FSM, registered state; outputs decoded from state; data path combinational.
//  IDLE:
//   If packet_req_i & |req_v_i: grant = first set bit after last_r (wrapping); latch size.
//   Bad size (0 or >eth_mtu_p):
//    same cycle pulse req_yumi_o[g]+err_o[g]; last_r<=g; stay IDLE.
//   Else: go SIZE.
//   No grant while packet_req_i=0.
//  SIZE (1 cycle):
//   packet_wsize_valid_o=1, packet_wsize_o=size_r, req_yumi_o[g]=1.
//   beats_r=ceil(size_r/bpw); addr_r=0; go DATA.
//  DATA:
//   data_ready_o[g]=1 (others 0). On data_v_i[g]: packet_wvalid_o=1, packet_wdata_o=data_i[g],
//   packet_waddr_o=addr_r.
//   addr_r+=bpw; beats_r-=1. Last beat (beats_r==1) -> SEND. Gaps in data_v_i stall, no write.
//  SEND (1 cycle):
//   packet_send_o=1, done_o[g]=1, last_r<=g; go WAIT.
//  WAIT (1 cycle):
//   covers sender's registered packet_req_i drop; go IDLE.
//  Latency: req_v_i rise (packet_req_i=1, IDLE) -> wsize_valid 1 cycle later.
//   Final data beat -> packet_send_o 1 cycle later.
//  Last partial word written whole; bytes beyond size ignored by sender.
//  Requester must hold req_v_i/req_size_i stable until req_yumi_o; dropping early is a
//   protocol error (simulation assertion). New requests during busy wait; no preemption.
//  Requests arriving in the SEND cycle compete at next IDLE; rr pointer guarantees no starvation.
// TESTING
//  1) req0 size=64, data 0..15, packet_req_i=1 -> wsize_valid once (64); 16 wvalid waddr 0,4..60;
//     then send pulse, done_o[0].
//  2) size=5 -> wsize 5, 2 beats waddr 0,4, send; size=2048 -> 512 beats, last waddr 2044.
//  3) req0,req1 both valid for 3 packets each -> grant order 0,1,0,1,0,1; done_o order matches.
//  4) size=0 and size=2049 -> err_o+req_yumi_o pulse same cycle; no wsize_valid/wvalid/send.
//  5) data_v_i toggling 1,0,0,1 during DATA; packet_req_i=0 in IDLE ->
//     writes only on handshakes, waddr contiguous; no grant until packet_req_i=1.
//  6) reset_i asserted after 3 beats of 16 -> all outputs 0 next cycle, no send, state IDLE,
//     req0 wins first after release.

Source files
------------

// File: rtl/ethernet_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// ethernet_tx_scheduler_if
// Bundles every requester-side and sender-side signal of the TX scheduler.
//   master : the scheduler itself (drives grants, handshakes, sender writes)
//   slave  : the requesters and the ethernet_sender buffer facing the scheduler
// Requester fields are packed one slice per requester (requester 0 in the
// least significant slice).
// ---------------------------------------------------------------------------
interface ethernet_tx_scheduler_if #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int num_req_p    = 2
);
   localparam int size_w = $clog2(eth_mtu_p + 1);
   localparam int addr_w = $clog2(eth_mtu_p);
   localparam int id_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int wds_w  = $clog2(size_w);

   // requester side
   logic [num_req_p-1:0]              req_v_i;
   logic [num_req_p*size_w-1:0]       req_size_i;
   logic [num_req_p-1:0]              req_yumi_o;
   logic [num_req_p-1:0]              data_v_i;
   logic [num_req_p*data_width_p-1:0] data_i;
   logic [num_req_p-1:0]              data_ready_o;
   logic [num_req_p-1:0]              done_o;
   logic [num_req_p-1:0]              err_o;
   logic                              busy_o;
   logic [id_w-1:0]                   grant_id_o;

   // sender side
   logic                              packet_req_i;
   logic                              packet_wsize_valid_o;
   logic [size_w-1:0]                 packet_wsize_o;
   logic                              packet_wvalid_o;
   logic [addr_w-1:0]                 packet_waddr_o;
   logic [data_width_p-1:0]           packet_wdata_o;
   logic [wds_w-1:0]                  packet_wdata_size_o;
   logic                              packet_send_o;

   modport master (
      input  req_v_i, req_size_i, data_v_i, data_i, packet_req_i,
      output req_yumi_o, data_ready_o, done_o, err_o, busy_o, grant_id_o,
             packet_wsize_valid_o, packet_wsize_o, packet_wvalid_o,
             packet_waddr_o, packet_wdata_o, packet_wdata_size_o, packet_send_o
   );

   modport slave (
      output req_v_i, req_size_i, data_v_i, data_i, packet_req_i,
      input  req_yumi_o, data_ready_o, done_o, err_o, busy_o, grant_id_o,
             packet_wsize_valid_o, packet_wsize_o, packet_wvalid_o,
             packet_waddr_o, packet_wdata_o, packet_wdata_size_o, packet_send_o
   );
endinterface

// File: rtl/ethernet_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ethernet_tx_scheduler
// Shares the single ethernet_sender TX buffer among num_req_p requesters.
// Round-robin arbitration on packet descriptors; the winner's payload words are
// streamed into the sender buffer, then a one-cycle send pulse is issued.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous, active-high reset (aborts any packet in flight)
//   bus      : ethernet_tx_scheduler_if.master
//              requester side: req_v/req_size/req_yumi, data_v/data/data_ready,
//                              done, err, busy, grant_id
//              sender side   : packet_req, packet_wsize_valid/wsize,
//                              packet_wvalid/waddr/wdata/wdata_size, packet_send
// ---------------------------------------------------------------------------
module ethernet_tx_scheduler #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int num_req_p    = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   ethernet_tx_scheduler_if.master bus
);
   localparam int bpw    = data_width_p / 8;
   localparam int lg_bpw = $clog2(bpw);
   localparam int size_w = $clog2(eth_mtu_p + 1);
   localparam int addr_w = $clog2(eth_mtu_p);
   localparam int id_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int wds_w  = $clog2(size_w);

   localparam logic [size_w-1:0] bpw_m1  = size_w'(bpw - 1);
   localparam logic [size_w-1:0] mtu_sz  = size_w'(eth_mtu_p);
   localparam logic [addr_w-1:0] bpw_adr = addr_w'(bpw);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SIZE = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_WAIT = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [id_w-1:0]   last_q,  last_d;
   logic [id_w-1:0]   grant_q, grant_d;
   logic [size_w-1:0] size_q,  size_d;
   logic [size_w-1:0] beats_q, beats_d;
   logic [addr_w-1:0] addr_q,  addr_d;

   // per-requester views of the packed buses
   logic [size_w-1:0]       req_size_a [num_req_p];
   logic [data_width_p-1:0] data_a     [num_req_p];

   for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
      assign req_size_a[gi] = bus.req_size_i[gi*size_w +: size_w];
      assign data_a[gi]     = bus.data_i[gi*data_width_p +: data_width_p];
   end

   // Round-robin pick: lowest requesting index strictly above last_q, else the
   // lowest requesting index overall (wrap-around, may be last_q itself).
   logic            hi_found, lo_found;
   logic [id_w-1:0] hi_id, lo_id, pick_id;

   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (bus.req_v_i[i]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_id    = id_w'(i);
            end
            if (!hi_found && (i > int'(last_q))) begin
               hi_found = 1'b1;
               hi_id    = id_w'(i);
            end
         end
      end
      pick_id = hi_found ? hi_id : lo_id;
   end

   logic [size_w-1:0] pick_size;
   logic              pick_bad;

   assign pick_size = req_size_a[pick_id];
   assign pick_bad  = (pick_size == '0) || (pick_size > mtu_sz);

   logic [num_req_p-1:0] yumi, err, done, ready;
   logic                 wsize_valid, wvalid, send;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      size_d      = size_q;
      beats_d     = beats_q;
      addr_d      = addr_q;
      yumi        = '0;
      err         = '0;
      done        = '0;
      ready       = '0;
      wsize_valid = 1'b0;
      wvalid      = 1'b0;
      send        = 1'b0;

      // Strobes are suppressed while reset is held so an aborted packet can
      // never produce a send pulse or a stray write.
      if (!reset_i) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.packet_req_i && lo_found) begin
                  grant_d = pick_id;
                  size_d  = pick_size;
                  if (pick_bad) begin
                     // rejected descriptors are consumed immediately
                     yumi[pick_id] = 1'b1;
                     err[pick_id]  = 1'b1;
                     last_d        = pick_id;
                  end else begin
                     state_d = ST_SIZE;
                  end
               end
            end
            ST_SIZE: begin
               wsize_valid    = 1'b1;
               yumi[grant_q]  = 1'b1;
               beats_d        = (size_q + bpw_m1) >> lg_bpw;
               addr_d         = '0;
               state_d        = ST_DATA;
            end
            ST_DATA: begin
               ready[grant_q] = 1'b1;
               if (bus.data_v_i[grant_q]) begin
                  wvalid  = 1'b1;
                  addr_d  = addr_q + bpw_adr;
                  beats_d = beats_q - size_w'(1);
                  if (beats_q == size_w'(1)) begin
                     state_d = ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               send          = 1'b1;
               done[grant_q] = 1'b1;
               last_d        = grant_q;
               state_d       = ST_WAIT;
            end
            ST_WAIT: begin
               // gives the sender a cycle to drop its registered packet_req
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         last_q  <= id_w'(num_req_p - 1);
         grant_q <= '0;
         size_q  <= '0;
         beats_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         size_q  <= size_d;
         beats_q <= beats_d;
         addr_q  <= addr_d;
      end
   end

   assign bus.req_yumi_o           = yumi;
   assign bus.err_o                = err;
   assign bus.done_o               = done;
   assign bus.data_ready_o         = ready;
   assign bus.busy_o               = (state_q != ST_IDLE);
   assign bus.grant_id_o           = grant_q;
   assign bus.packet_wsize_valid_o = wsize_valid;
   assign bus.packet_wsize_o       = wsize_valid ? size_q : '0;
   assign bus.packet_wvalid_o      = wvalid;
   assign bus.packet_waddr_o       = wvalid ? addr_q : '0;
   assign bus.packet_wdata_o       = wvalid ? data_a[grant_q] : '0;
   assign bus.packet_wdata_size_o  = wds_w'(lg_bpw);
   assign bus.packet_send_o        = send;

   // A requester must keep its descriptor valid and unchanged until consumed.
   for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req_hold
      a_req_hold: assert property (@(posedge clk_i) disable iff (reset_i)
         (bus.req_v_i[gi] && !bus.req_yumi_o[gi]) |=>
         (bus.req_v_i[gi] && $stable(req_size_a[gi])));
   end
endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ethernet_tx_scheduler
// Requester driver tasks push each descriptor's expectation into a
// per-requester queue; a negedge monitor pops and checks whatever the DUT
// presents (grants, size writes, data writes, send/done pulses).
// ---------------------------------------------------------------------------
module tb_ethernet_tx_scheduler;
   localparam int DW  = 32;
   localparam int MTU = 2048;
   localparam int NR  = 2;
   localparam int SW  = $clog2(MTU + 1);
   localparam int BPW = DW / 8;
   localparam int TMO = 5000;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;

   ethernet_tx_scheduler_if #(.data_width_p(DW), .eth_mtu_p(MTU), .num_req_p(NR)) bus ();

   ethernet_tx_scheduler #(.data_width_p(DW), .eth_mtu_p(MTU), .num_req_p(NR)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   // per-requester drive state
   logic          drv_req_v  [NR];
   logic [SW-1:0] drv_size   [NR];
   logic          drv_data_v [NR];
   logic [DW-1:0] drv_data   [NR];
   logic          drv_packet_req;

   logic [NR-1:0]    req_v_pk, data_v_pk;
   logic [NR*SW-1:0] size_pk;
   logic [NR*DW-1:0] data_pk;

   always_comb begin
      req_v_pk  = '0;
      data_v_pk = '0;
      size_pk   = '0;
      data_pk   = '0;
      for (int i = 0; i < NR; i++) begin
         req_v_pk[i]          = drv_req_v[i];
         data_v_pk[i]         = drv_data_v[i];
         size_pk[i*SW +: SW]  = drv_size[i];
         data_pk[i*DW +: DW]  = drv_data[i];
      end
   end

   assign bus.req_v_i      = req_v_pk;
   assign bus.req_size_i   = size_pk;
   assign bus.data_v_i     = data_v_pk;
   assign bus.data_i       = data_pk;
   assign bus.packet_req_i = drv_packet_req;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] word_of(input int r, input int seq, input int k);
      return DW'((r << 28) | ((seq & 32'hfff) << 16) | (k & 32'hffff));
   endfunction

   // reference round-robin rule: first requesting index after last, wrapping
   function automatic int rr_pick(input logic [NR-1:0] set, input int last);
      for (int off = 1; off <= NR; off++) begin
         if (set[(last + off) % NR]) return (last + off) % NR;
      end
      return -1;
   endfunction

   // scoreboard
   int exp_size_q [NR][$];
   int exp_seq_q  [NR][$];
   int seq_cnt    [NR];
   int grant_log[$];
   int done_log[$];

   // monitor state
   int            mon_last = NR - 1;
   logic [NR-1:0] req_prev = '0;
   logic          pktreq_prev = 1'b0;
   bit            cur_active = 0;
   bit            send_due = 0;
   int            cur_r, cur_size, cur_seq, cur_k, cur_beats;
   int            cyc = 0;
   int            wsize_cyc = 0;
   int            last_waddr = -1;

   always @(negedge clk_i) begin
      int  g, exp_g, sz, sq;
      bit  is_err, bad;
      logic [NR-1:0] set;
      cyc++;
      if (reset_i) begin
         cur_active  = 0;
         send_due    = 0;
         mon_last    = NR - 1;
         req_prev    = '0;
         pktreq_prev = 1'b0;
         for (int r = 0; r < NR; r++) begin
            exp_size_q[r].delete();
            exp_seq_q[r].delete();
         end
      end else begin
         if (send_due) begin
            chk("send_after_last_beat", longint'(bus.packet_send_o), 1);
            chk("done_bits", longint'(bus.done_o), longint'(1 << cur_r));
            if (bus.done_o[cur_r]) done_log.push_back(cur_r);
            send_due   = 0;
            cur_active = 0;
         end else if (bus.packet_send_o || bus.done_o != '0) begin
            chk("unexpected_send", longint'(bus.packet_send_o), 0);
            chk("unexpected_done", longint'(bus.done_o), 0);
         end

         if (bus.req_yumi_o != '0) begin
            g = 0;
            for (int i = NR - 1; i >= 0; i--) if (bus.req_yumi_o[i]) g = i;
            chk("yumi_onehot", longint'($countones(bus.req_yumi_o)), 1);
            is_err = bus.err_o[g];
            // a rejected descriptor is consumed in its grant cycle; a good one
            // one cycle after the grant, so judge fairness on that cycle's set
            set = is_err ? bus.req_v_i : req_prev;
            exp_g = rr_pick(set, mon_last);
            chk("grant_rr", g, exp_g);
            chk("packet_req_at_grant", longint'(is_err ? bus.packet_req_i : pktreq_prev), 1);
            grant_log.push_back(g);
            mon_last = g;
            if (exp_size_q[g].size() == 0) begin
               chk("grant_without_request", 1, 0);
            end else begin
               sz  = exp_size_q[g].pop_front();
               sq  = exp_seq_q[g].pop_front();
               bad = (sz == 0) || (sz > MTU);
               chk("err_bits", longint'(bus.err_o), bad ? longint'(1 << g) : 0);
               chk("wsize_valid", longint'(bus.packet_wsize_valid_o), bad ? 0 : 1);
               if (!bad) begin
                  chk("wsize", longint'(bus.packet_wsize_o), sz);
                  chk("grant_id", longint'(bus.grant_id_o), g);
                  cur_active = 1;
                  cur_r      = g;
                  cur_size   = sz;
                  cur_seq    = sq;
                  cur_k      = 0;
                  cur_beats  = (sz + BPW - 1) / BPW;
                  wsize_cyc  = cyc;
               end
            end
         end else begin
            if (bus.err_o != '0) chk("err_without_yumi", longint'(bus.err_o), 0);
            if (bus.packet_wsize_valid_o) chk("unexpected_wsize_valid", 1, 0);
         end

         if (bus.packet_wvalid_o) begin
            if (!cur_active || send_due || cur_k >= cur_beats) begin
               chk("unexpected_write", 1, 0);
            end else begin
               chk("waddr", longint'(bus.packet_waddr_o), cur_k * BPW);
               chk("wdata", longint'(bus.packet_wdata_o), longint'(word_of(cur_r, cur_seq, cur_k)));
               chk("data_ready", longint'(bus.data_ready_o), longint'(1 << cur_r));
               last_waddr = int'(bus.packet_waddr_o);
               cur_k++;
               if (cur_k == cur_beats) send_due = 1;
            end
         end

         req_prev    = bus.req_v_i;
         pktreq_prev = bus.packet_req_i;
      end
   end

   // Issue one descriptor from requester r and stream its payload.
   // mode 0: data always valid; 1: random gaps; 2: pattern 1,0,0,1.
   // stop_beats > 0 abandons the payload after that many accepted beats.
   task automatic send_pkt(input int r, input int size, input int mode, input int stop_beats);
      int  seq, beats, k, c, t;
      bit  bad, v, hs, got;
      bad = (size == 0) || (size > MTU);
      seq = seq_cnt[r];
      seq_cnt[r]++;
      exp_size_q[r].push_back(size);
      exp_seq_q[r].push_back(seq);
      drv_size[r]  = SW'(size);
      drv_req_v[r] = 1'b1;
      got = 0;
      t   = 0;
      while (!got) begin
         @(negedge clk_i);
         if (bus.req_yumi_o[r]) got = 1;
         else begin
            t++;
            if (t > TMO) begin
               chk("req_timeout", 0, 1);
               @(posedge clk_i); #1;
               drv_req_v[r] = 1'b0;
               return;
            end
         end
      end
      @(posedge clk_i); #1;
      drv_req_v[r] = 1'b0;
      if (bad) return;
      beats = (size + BPW - 1) / BPW;
      k = 0;
      c = 0;
      while (k < beats && !(stop_beats > 0 && k >= stop_beats)) begin
         drv_data[r] = word_of(r, seq, k);
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 3) != 0);
            default: v = ((c % 4) == 0) || ((c % 4) == 3);
         endcase
         drv_data_v[r] = v;
         @(negedge clk_i);
         hs = v && bus.data_ready_o[r];
         @(posedge clk_i); #1;
         if (hs) k++;
         c++;
         if (c > TMO) begin
            chk("data_timeout", 0, 1);
            break;
         end
      end
      drv_data_v[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int  t, quiet;
      bit  empty;
      t = 0;
      quiet = 0;
      while (quiet < 3) begin
         @(negedge clk_i);
         empty = 1;
         for (int r = 0; r < NR; r++) if (exp_size_q[r].size() != 0) empty = 0;
         if (!bus.busy_o && !cur_active && empty) quiet++;
         else quiet = 0;
         t++;
         if (t > 20000) begin
            chk("idle_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk_i); #1;
   endtask

   task automatic check_quiet_outputs(input string tag);
      chk({tag, "_busy"},        longint'(bus.busy_o), 0);
      chk({tag, "_yumi"},        longint'(bus.req_yumi_o), 0);
      chk({tag, "_ready"},       longint'(bus.data_ready_o), 0);
      chk({tag, "_wsize_valid"}, longint'(bus.packet_wsize_valid_o), 0);
      chk({tag, "_wvalid"},      longint'(bus.packet_wvalid_o), 0);
      chk({tag, "_send"},        longint'(bus.packet_send_o), 0);
      chk({tag, "_done"},        longint'(bus.done_o), 0);
      chk({tag, "_grant_id"},    longint'(bus.grant_id_o), 0);
      chk({tag, "_wdata_size"},  longint'(bus.packet_wdata_size_o), $clog2(BPW));
   endtask

   bit rand_done = 0;

   initial begin
      int t0;
      for (int r = 0; r < NR; r++) begin
         drv_req_v[r]  = 1'b0;
         drv_size[r]   = '0;
         drv_data_v[r] = 1'b0;
         drv_data[r]   = '0;
         seq_cnt[r]    = 0;
      end
      drv_packet_req = 1'b1;
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_quiet_outputs("reset");
      @(posedge clk_i); #1;
      reset_i = 1'b0;

      // 1) 64-byte packet, wsize one cycle after the request
      t0 = cyc;
      send_pkt(0, 64, 0, 0);
      wait_idle();
      chk("t1_wsize_latency", wsize_cyc - t0, 2);
      chk("t1_done_req", done_log.size() > 0 ? done_log[$] : -1, 0);

      // 2) odd length and maximum length
      send_pkt(0, 5, 1, 0);
      wait_idle();
      chk("t2_last_waddr_5", last_waddr, 4);
      send_pkt(1, MTU, 0, 0);
      wait_idle();
      chk("t2_last_waddr_mtu", last_waddr, MTU - 4);

      // 3) two requesters competing for three packets each
      grant_log.delete();
      done_log.delete();
      fork
         begin
            for (int i = 0; i < 3; i++) send_pkt(0, $urandom_range(1, 40), 1, 0);
         end
         begin
            for (int i = 0; i < 3; i++) send_pkt(1, $urandom_range(1, 40), 1, 0);
         end
      join
      wait_idle();
      chk("t3_grant_count", grant_log.size(), 6);
      chk("t3_done_count", done_log.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("t3_grant_order", i < grant_log.size() ? grant_log[i] : -1, i % 2);
         chk("t3_done_order", i < done_log.size() ? done_log[i] : -1, i % 2);
      end

      // 4) rejected sizes
      done_log.delete();
      send_pkt(0, 0, 0, 0);
      send_pkt(1, MTU + 1, 0, 0);
      wait_idle();
      chk("t4_no_done", done_log.size(), 0);

      // 5) stalled data and sender not ready
      drv_packet_req = 1'b0;
      fork
         send_pkt(0, 20, 2, 0);
         begin
            repeat (10) begin
               @(negedge clk_i);
               chk("t5_no_grant_yumi", longint'(bus.req_yumi_o), 0);
               chk("t5_no_grant_busy", longint'(bus.busy_o), 0);
            end
            @(posedge clk_i); #1;
            drv_packet_req = 1'b1;
         end
      join
      wait_idle();
      chk("t5_last_waddr", last_waddr, 16);

      // 6) reset in the middle of a packet
      send_pkt(0, 64, 0, 3);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_quiet_outputs("t6_reset");
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      grant_log.delete();
      fork
         send_pkt(1, 8, 0, 0);
         send_pkt(0, 8, 0, 0);
      join
      wait_idle();
      chk("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      chk("t6_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 1);

      // randomized traffic with a flickering sender ready
      fork
         begin
            fork
               for (int r = 0; r < NR; r++) begin
                  automatic int rr = r;
                  fork
                     begin
                        for (int n = 0; n < 25; n++) begin
                           int pick, sz;
                           pick = $urandom_range(0, 19);
                           if (pick == 0)      sz = 0;
                           else if (pick == 1) sz = MTU + 1;
                           else if (pick == 2) sz = $urandom_range(1000, MTU);
                           else                sz = $urandom_range(1, 130);
                           send_pkt(rr, sz, 1, 0);
                        end
                     end
                  join_none
               end
            join
            wait fork;
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk_i); #1;
               drv_packet_req = ($urandom_range(0, 3) != 0);
            end
            drv_packet_req = 1'b1;
         end
      join
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
